// File: rtl/ift_shared_sram_arbiter_if.sv
// Request/response bundle between the CPU memory ports and the shared SRAM,
// with a taint shadow (*_t0) next to every data signal.
interface ift_shared_sram_arbiter_if #(
  parameter int NumPorts = 2
);
  logic [NumPorts-1:0]    req_i;
  logic [NumPorts-1:0]    we_i;
  logic [NumPorts*32-1:0] addr_i;
  logic [NumPorts*32-1:0] wdata_i;
  logic [NumPorts*4-1:0]  strb_i;
  logic [NumPorts-1:0]    req_t0;
  logic [NumPorts-1:0]    we_t0;
  logic [NumPorts*32-1:0] addr_t0;
  logic [NumPorts*32-1:0] wdata_t0;
  logic [NumPorts*4-1:0]  strb_t0;

  logic [NumPorts-1:0]    gnt_o;
  logic [NumPorts-1:0]    rvalid_o;
  logic [NumPorts*32-1:0] rdata_o;
  logic [NumPorts-1:0]    err_o;
  logic [NumPorts-1:0]    gnt_t0;
  logic [NumPorts-1:0]    rvalid_t0;
  logic [NumPorts*32-1:0] rdata_t0;
  logic [NumPorts-1:0]    err_t0;

  modport master (
    output req_i, we_i, addr_i, wdata_i, strb_i,
    output req_t0, we_t0, addr_t0, wdata_t0, strb_t0,
    input  gnt_o, rvalid_o, rdata_o, err_o,
    input  gnt_t0, rvalid_t0, rdata_t0, err_t0
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, strb_i,
    input  req_t0, we_t0, addr_t0, wdata_t0, strb_t0,
    output gnt_o, rvalid_o, rdata_o, err_o,
    output gnt_t0, rvalid_t0, rdata_t0, err_t0
  );
endinterface

// File: rtl/ift_shared_sram_arbiter.sv
// Shared single-array SRAM with round-robin arbitration, fixed read latency
// and a per-bit taint shadow carried through grant, storage and response.
module ift_shared_sram_arbiter #(
  parameter int          NumPorts    = 2,
  parameter int          Depth       = 1024,
  parameter int          ReadLatency = 1,
  parameter logic [31:0] BaseAddr    = 32'h8000_0000
) (
  input logic clk_i,
  input logic rst_i,
  ift_shared_sram_arbiter_if.slave bus
);
  localparam int PtrW  = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam int AddrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int Last  = ReadLatency - 1;

  logic [PtrW-1:0]  ptr_q;
  logic             found;
  logic             acc;
  logic [PtrW-1:0]  win;
  logic [NumPorts-1:0] gnt;
  logic             req_taint;

  logic             we_s, we_t0_s;
  logic [31:0]      addr_s, wdata_s, addr_t0_s, wdata_t0_s;
  logic [3:0]       strb_s, strb_t0_s;

  logic [31:0]      off, word;
  logic             in_range, widx_ok, force_t, addr_tainted;
  logic [AddrW-1:0] widx;

  logic [31:0]      mem_q   [Depth];
  logic [31:0]      taint_q [Depth];

  logic [ReadLatency-1:0] pv_q;
  logic [PtrW-1:0]  pport_q [ReadLatency];
  logic [31:0]      pdata_q [ReadLatency];
  logic [31:0]      pdt_q   [ReadLatency];
  logic             perr_q  [ReadLatency];
  logic             pet_q   [ReadLatency];
  logic             pgt_q   [ReadLatency];

  // Round-robin search starting at the pointer; reset suppresses any grant.
  always_comb begin : arb
    int cand;
    found = 1'b0;
    win   = '0;
    cand  = 0;
    for (int i = 0; i < NumPorts; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= NumPorts) cand = cand - NumPorts;
      if (!found && bus.req_i[PtrW'(cand)]) begin
        found = 1'b1;
        win   = PtrW'(cand);
      end
    end
    acc = found && !rst_i;
    for (int p = 0; p < NumPorts; p++) gnt[p] = acc && (PtrW'(p) == win);
  end

  assign req_taint  = |(bus.req_t0 & bus.req_i);
  assign bus.gnt_o  = gnt;
  assign bus.gnt_t0 = req_taint ? gnt : '0;

  always_comb begin
    we_s = 1'b0; we_t0_s = 1'b0;
    addr_s = '0; wdata_s = '0; addr_t0_s = '0; wdata_t0_s = '0;
    strb_s = '0; strb_t0_s = '0;
    for (int p = 0; p < NumPorts; p++) begin
      if (PtrW'(p) == win) begin
        we_s       = bus.we_i[p];
        we_t0_s    = bus.we_t0[p];
        addr_s     = bus.addr_i[p*32 +: 32];
        wdata_s    = bus.wdata_i[p*32 +: 32];
        strb_s     = bus.strb_i[p*4 +: 4];
        addr_t0_s  = bus.addr_t0[p*32 +: 32];
        wdata_t0_s = bus.wdata_t0[p*32 +: 32];
        strb_t0_s  = bus.strb_t0[p*4 +: 4];
      end
    end
  end

  assign off          = addr_s - BaseAddr;
  assign word         = off >> 2;
  assign in_range     = word < 32'(Depth);
  assign widx         = word[AddrW-1:0];
  assign widx_ok      = 32'(widx) < 32'(Depth);
  assign addr_tainted = |addr_t0_s;
  assign force_t      = addr_tainted | we_t0_s | (|strb_t0_s);

  always_ff @(posedge clk_i) begin
    if (acc && we_s && in_range) begin
      for (int b = 0; b < 4; b++)
        if (strb_s[b]) mem_q[widx][b*8 +: 8] <= wdata_s[b*8 +: 8];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
      pv_q  <= '0;
      for (int i = 0; i < Depth; i++) taint_q[i] <= '0;
      for (int s = 0; s < ReadLatency; s++) begin
        pport_q[s] <= '0; pdata_q[s] <= '0; pdt_q[s] <= '0;
        perr_q[s]  <= 1'b0; pet_q[s] <= 1'b0; pgt_q[s] <= 1'b0;
      end
    end else begin
      if (acc) ptr_q <= (win == PtrW'(NumPorts - 1)) ? '0 : win + 1'b1;
      // A tainted address/strobe/we may have hit any byte, so poison the whole word.
      if (acc && (we_s || we_t0_s)) begin
        if (force_t) begin
          if (widx_ok) taint_q[widx] <= '1;
        end else if (we_s && in_range) begin
          for (int b = 0; b < 4; b++)
            if (strb_s[b]) taint_q[widx][b*8 +: 8] <= wdata_t0_s[b*8 +: 8];
        end
      end
      pv_q[0]    <= acc;
      pport_q[0] <= win;
      pdata_q[0] <= (!we_s && in_range) ? mem_q[widx] : '0;
      pdt_q[0]   <= (addr_tainted || we_t0_s) ? '1 :
                    ((!we_s && in_range) ? taint_q[widx] : '0);
      perr_q[0]  <= !in_range;
      pet_q[0]   <= addr_tainted;
      pgt_q[0]   <= req_taint;
      for (int s = 1; s < ReadLatency; s++) begin
        pv_q[s]    <= pv_q[s-1];
        pport_q[s] <= pport_q[s-1];
        pdata_q[s] <= pdata_q[s-1];
        pdt_q[s]   <= pdt_q[s-1];
        perr_q[s]  <= perr_q[s-1];
        pet_q[s]   <= pet_q[s-1];
        pgt_q[s]   <= pgt_q[s-1];
      end
    end
  end

  always_comb begin
    bus.rvalid_o  = '0;
    bus.rdata_o   = '0;
    bus.err_o     = '0;
    bus.rvalid_t0 = '0;
    bus.rdata_t0  = '0;
    bus.err_t0    = '0;
    for (int p = 0; p < NumPorts; p++) begin
      if (pv_q[Last] && (PtrW'(p) == pport_q[Last])) begin
        bus.rvalid_o[p]          = 1'b1;
        bus.rdata_o[p*32 +: 32]  = pdata_q[Last];
        bus.err_o[p]             = perr_q[Last];
        bus.rvalid_t0[p]         = pgt_q[Last];
        bus.rdata_t0[p*32 +: 32] = pdt_q[Last];
        bus.err_t0[p]            = pet_q[Last];
      end
    end
  end
endmodule
